// File: rtl/name_mem_ctrl.sv
// name_mem_ctrl: command sequencer for the 32x8 name memory.
// Stores a whole name into a fixed-size slot, loads one back out, or clears the memory.
// The accepted name bytes arrive on a valid/ready stream, and the loaded bytes leave on another.
//
// Ports:
//   Clk, Rst                 clock (rising edge), asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready  command handshake; ready only while idle
//   i_cmd_op, i_cmd_slot     00 NOP, 01 STORE, 10 LOAD, 11 CLEAR; target slot
//   i_in_data/valid, o_in_ready      STORE byte stream
//   o_out_data/valid, i_out_ready    LOAD byte stream
//   o_done, o_busy           one-cycle completion pulse; not-idle flag
//   o_nm_addr, o_nm_wdata    memory address and write data
//   o_nm_wnm/rnm/initnm      memory write / read / clear strobes
//   i_nm_rdata               registered memory read data
module name_mem_ctrl #(
   parameter int unsigned SLOT_LEN  = 8,
   parameter int unsigned NUM_SLOTS = 4
) (
   input  logic                         Clk,
   input  logic                         Rst,
   input  logic                         i_cmd_valid,
   output logic                         o_cmd_ready,
   input  logic [1:0]                   i_cmd_op,
   input  logic [$clog2(NUM_SLOTS)-1:0] i_cmd_slot,
   input  logic [7:0]                   i_in_data,
   input  logic                         i_in_valid,
   output logic                         o_in_ready,
   output logic [7:0]                   o_out_data,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic                         o_done,
   output logic                         o_busy,
   output logic [4:0]                   o_nm_addr,
   output logic [7:0]                   o_nm_wdata,
   output logic                         o_nm_wnm,
   output logic                         o_nm_rnm,
   output logic                         o_nm_initnm,
   input  logic [7:0]                   i_nm_rdata
);

   localparam int unsigned SlotW = $clog2(NUM_SLOTS);
   localparam int unsigned IdxW  = $clog2(SLOT_LEN);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(SLOT_LEN - 1);

   localparam logic [1:0] OpStore = 2'b01;
   localparam logic [1:0] OpLoad  = 2'b10;
   localparam logic [1:0] OpClear = 2'b11;

   typedef enum logic [2:0] {
      StIdle, StStore, StPad, StRd, StWait, StOut, StClear, StDone
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [IdxW-1:0]  r_idx, w_idx_nxt;
   logic [SlotW-1:0] r_slot, w_slot_nxt;
   logic             r_cmd_ready, w_cmd_ready_nxt;
   logic             r_in_ready, w_in_ready_nxt;
   logic [7:0]       r_out_data, w_out_data_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_done, w_done_nxt;
   logic             r_busy, w_busy_nxt;
   logic [4:0]       r_nm_addr, w_addr_nxt;
   logic [7:0]       r_nm_wdata, w_wdata_nxt;
   logic             r_nm_wnm, w_wnm_nxt;
   logic             r_nm_rnm, w_rnm_nxt;
   logic             r_nm_initnm, w_initnm_nxt;

   logic [IdxW-1:0]  w_idx_inc;
   logic             w_last;
   logic [4:0]       w_addr_cur;
   logic [4:0]       w_addr_inc;

   assign w_idx_inc  = r_idx + IdxW'(1);
   assign w_last     = (r_idx == LastIdx);
   // Slot length is a power of two, so slot*SLOT_LEN + idx is a plain concatenation.
   assign w_addr_cur = 5'({r_slot, r_idx});
   assign w_addr_inc = 5'({r_slot, w_idx_inc});

   always_comb begin
      w_state_nxt     = r_state;
      w_idx_nxt       = r_idx;
      w_slot_nxt      = r_slot;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
      w_addr_nxt      = r_nm_addr;
      w_wdata_nxt     = r_nm_wdata;
      w_wnm_nxt       = 1'b0;
      w_rnm_nxt       = 1'b0;
      w_initnm_nxt    = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_idx_nxt = '0;
            if (i_cmd_valid && r_cmd_ready) begin
               w_slot_nxt = i_cmd_slot;
               case (i_cmd_op)
                  OpStore: w_state_nxt = StStore;
                  OpLoad: begin
                     w_state_nxt = StRd;
                     w_rnm_nxt   = 1'b1;
                     w_addr_nxt  = 5'({i_cmd_slot, {IdxW{1'b0}}});
                  end
                  OpClear: begin
                     w_state_nxt  = StClear;
                     w_initnm_nxt = 1'b1;
                  end
                  default: w_state_nxt = StDone;
               endcase
            end
         end
         StStore: begin
            if (i_in_valid && r_in_ready) begin
               w_wnm_nxt   = 1'b1;
               w_addr_nxt  = w_addr_cur;
               w_wdata_nxt = i_in_data;
               if (w_last) begin
                  w_state_nxt = StDone;
               end else begin
                  w_idx_nxt = w_idx_inc;
                  if (i_in_data == 8'h00) w_state_nxt = StPad;
               end
            end
         end
         StPad: begin
            // Zero-fill the tail so a shorter name never exposes stale bytes.
            w_wnm_nxt   = 1'b1;
            w_addr_nxt  = w_addr_cur;
            w_wdata_nxt = 8'h00;
            if (w_last) w_state_nxt = StDone;
            else        w_idx_nxt   = w_idx_inc;
         end
         StRd: w_state_nxt = StWait;
         StWait: begin
            w_out_data_nxt  = i_nm_rdata;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = StOut;
         end
         StOut: begin
            if (i_out_ready) begin
               w_out_valid_nxt = 1'b0;
               if (r_out_data == 8'h00 || w_last) begin
                  w_state_nxt = StDone;
               end else begin
                  w_idx_nxt   = w_idx_inc;
                  w_rnm_nxt   = 1'b1;
                  w_addr_nxt  = w_addr_inc;
                  w_state_nxt = StRd;
               end
            end
         end
         StClear: w_state_nxt = StDone;
         StDone:  w_state_nxt = StIdle;
      endcase

      // Status outputs are registered copies of the next state.
      w_cmd_ready_nxt = (w_state_nxt == StIdle);
      w_busy_nxt      = (w_state_nxt != StIdle);
      w_in_ready_nxt  = (w_state_nxt == StStore);
      w_done_nxt      = (w_state_nxt == StDone);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state     <= StIdle;
         r_idx       <= '0;
         r_slot      <= '0;
         r_cmd_ready <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_nm_addr   <= 5'd0;
         r_nm_wdata  <= 8'h00;
         r_nm_wnm    <= 1'b0;
         r_nm_rnm    <= 1'b0;
         r_nm_initnm <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_slot      <= w_slot_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_done      <= w_done_nxt;
         r_busy      <= w_busy_nxt;
         r_nm_addr   <= w_addr_nxt;
         r_nm_wdata  <= w_wdata_nxt;
         r_nm_wnm    <= w_wnm_nxt;
         r_nm_rnm    <= w_rnm_nxt;
         r_nm_initnm <= w_initnm_nxt;
      end
   end

   assign o_cmd_ready = r_cmd_ready;
   assign o_in_ready  = r_in_ready;
   assign o_out_data  = r_out_data;
   assign o_out_valid = r_out_valid;
   assign o_done      = r_done;
   assign o_busy      = r_busy;
   assign o_nm_addr   = r_nm_addr;
   assign o_nm_wdata  = r_nm_wdata;
   assign o_nm_wnm    = r_nm_wnm;
   assign o_nm_rnm    = r_nm_rnm;
   assign o_nm_initnm = r_nm_initnm;

endmodule

// File: tb/tb_name_mem_ctrl.sv
// tb_name_mem_ctrl: bench for name_mem_ctrl. Models the 32x8 name memory the controller drives,
// and keeps a separate reference image of what the memory should hold after each command.
module tb_name_mem_ctrl;

   localparam int SlotLen = 8;
   localparam logic [1:0] OpNop   = 2'b00;
   localparam logic [1:0] OpStore = 2'b01;
   localparam logic [1:0] OpLoad  = 2'b10;
   localparam logic [1:0] OpClear = 2'b11;

   logic       Clk       = 1'b0;
   logic       Rst       = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op    = 2'b00;
   logic [1:0] cmd_slot  = 2'b00;
   logic [7:0] in_data   = 8'h00;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b0;
   logic       cmd_ready, in_ready, out_valid, done, busy;
   logic [7:0] out_data, nm_wdata, nm_rdata;
   logic [4:0] nm_addr;
   logic       nm_wnm, nm_rnm, nm_initnm;

   name_mem_ctrl #(.SLOT_LEN(8), .NUM_SLOTS(4)) u_dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .i_cmd_valid(cmd_valid),
      .o_cmd_ready(cmd_ready),
      .i_cmd_op   (cmd_op),
      .i_cmd_slot (cmd_slot),
      .i_in_data  (in_data),
      .i_in_valid (in_valid),
      .o_in_ready (in_ready),
      .o_out_data (out_data),
      .o_out_valid(out_valid),
      .i_out_ready(out_ready),
      .o_done     (done),
      .o_busy     (busy),
      .o_nm_addr  (nm_addr),
      .o_nm_wdata (nm_wdata),
      .o_nm_wnm   (nm_wnm),
      .o_nm_rnm   (nm_rnm),
      .o_nm_initnm(nm_initnm),
      .i_nm_rdata (nm_rdata)
   );

   always #5 Clk = ~Clk;

   // Name memory: write, read and clear all take effect on the rising edge.
   logic [7:0] mem [32];
   always @(posedge Clk) begin
      if (nm_initnm) for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      if (nm_wnm) mem[nm_addr] <= nm_wdata;
      if (nm_rnm) nm_rdata <= mem[nm_addr];
   end

   int cyc = 0, wnm_cnt = 0, rnm_cnt = 0, init_cnt = 0, done_cnt = 0, dual_cnt = 0;
   always @(posedge Clk) begin
      cyc++;
      if (nm_wnm)    wnm_cnt++;
      if (nm_rnm)    rnm_cnt++;
      if (nm_initnm) init_cnt++;
      if (done)      done_cnt++;
      if (int'(nm_wnm) + int'(nm_rnm) + int'(nm_initnm) > 1) dual_cnt++;
   end

   logic [7:0] ref_mem [32];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {3'b000, cmd_ready, in_ready, out_data, out_valid, done, busy,
              nm_addr, nm_wdata, nm_wnm, nm_rnm, nm_initnm};
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic mem_check(input string tag);
      int bad = 0;
      for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
      check_eq({tag, "_mem"}, bad, 0);
   endtask

   // Returns with the command accepted on the previous edge; acc is that edge's cycle stamp.
   task automatic issue_cmd(input logic [1:0] op, input logic [1:0] slot, output int acc,
                            input string tag);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_slot  = slot;
      while (!cmd_ready && n < 40) begin step(); n++; end
      if (!cmd_ready) check_eq({tag, "_cmd_timeout"}, cmd_ready, 1);
      step();
      acc       = cyc;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_slot  = 2'($urandom);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 200) begin step(); n++; end
      if (!done) check_eq({tag, "_done_timeout"}, done, 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input string tag);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 20) begin step(); n++; end
      if (!in_ready) check_eq({tag, "_in_timeout"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic do_store(input logic [1:0] slot, input logic [7:0] b [8], input int len,
                           input bit gaps, input string tag);
      int acc, w0, d0;
      w0 = wnm_cnt;
      d0 = done_cnt;
      issue_cmd(OpStore, slot, acc, tag);
      check_eq({tag, "_in_ready"}, in_ready, 1);
      for (int k = 0; k < len; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) step();
         send_byte(b[k], tag);
      end
      check_eq({tag, "_in_ready_drop"}, in_ready, 0);
      // A full-length name finishes straight away with no padding phase.
      if (len == SlotLen) check_eq({tag, "_no_pad"}, done, 1);
      wait_done(tag);
      step();
      check_eq({tag, "_wnm_pulses"}, wnm_cnt - w0, SlotLen);
      check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
      for (int i = 0; i < SlotLen; i++)
         ref_mem[int'(slot) * SlotLen + i] = (i < len) ? b[i] : 8'h00;
      mem_check(tag);
   endtask

   task automatic do_load(input logic [1:0] slot, input bit stall, input string tag);
      logic [7:0] exp_q [$];
      logic [7:0] got_q [$];
      logic [7:0] held = 8'h00;
      bit stalled = 1'b0;
      int acc, n = 0, first = -1, unstable = 0, r0, d0, bad = 0;
      // Expected: slot bytes up to and including the first 0x00, at most a full slot.
      for (int i = 0; i < SlotLen; i++) begin
         exp_q.push_back(ref_mem[int'(slot) * SlotLen + i]);
         if (ref_mem[int'(slot) * SlotLen + i] == 8'h00) break;
      end
      r0 = rnm_cnt;
      d0 = done_cnt;
      issue_cmd(OpLoad, slot, acc, tag);
      while (!done && n < 300) begin
         in_valid = 1'($urandom);
         in_data  = 8'($urandom);
         if (out_valid) begin
            if (first < 0) first = cyc - acc;
            if (stalled && out_data !== held) unstable++;
            held      = out_data;
            out_ready = stall ? 1'($urandom) : 1'b1;
            stalled   = !out_ready;
            if (out_ready) got_q.push_back(out_data);
         end else begin
            if (stalled) unstable++;
            stalled   = 1'b0;
            out_ready = 1'($urandom);
         end
         step();
         n++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      if (!done) check_eq({tag, "_done_timeout"}, done, 1);
      // Accept cycle, RD, WAIT, then out_valid: two edges after the accepting edge.
      check_eq({tag, "_first_valid"}, first, 2);
      check_eq({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
      check_eq({tag, "_bytes"}, bad, 0);
      check_eq({tag, "_stable"}, unstable, 0);
      step();
      check_eq({tag, "_reads"}, rnm_cnt - r0, exp_q.size());
      check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
   endtask

   task automatic do_clear(input string tag);
      int acc, i0, d0;
      i0 = init_cnt;
      d0 = done_cnt;
      issue_cmd(OpClear, 2'($urandom), acc, tag);
      check_eq({tag, "_initnm"}, nm_initnm, 1);
      step();
      check_eq({tag, "_initnm_low"}, nm_initnm, 0);
      check_eq({tag, "_done"}, done, 1);
      step();
      check_eq({tag, "_init_pulses"}, init_cnt - i0, 1);
      check_eq({tag, "_done_pulses"}, done_cnt - d0, 1);
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
      mem_check(tag);
   endtask

   task automatic do_nop(input string tag);
      int acc;
      issue_cmd(OpNop, 2'($urandom), acc, tag);
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_busy"}, busy, 1);
      check_eq({tag, "_cmd_ready_low"}, cmd_ready, 0);
      step();
      check_eq({tag, "_done_low"}, done, 0);
      check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   initial begin
      #400000;
      n_errors++;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end

   initial begin
      logic [7:0] bv [8];
      int acc, w0, sel, len;
      logic [1:0] s;

      #12;
      check_eq("reset_outputs", outs(), 0);
      @(negedge Clk);
      Rst = 1'b0;
      step();
      step();
      check_eq("post_reset_cmd_ready", cmd_ready, 1);
      check_eq("post_reset_busy", busy, 0);
      do_clear("clear_init");

      // "AB" plus terminator into slot 1: tail of the slot padded with zeros.
      bv = '{8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      do_store(2'd1, bv, 3, 1'b0, "store_ab");
      check_eq("store_ab_addr8", mem[8], 8'h41);
      check_eq("store_ab_addr9", mem[9], 8'h42);
      check_eq("store_ab_addr15", mem[15], 8'h00);

      // Full slot with no terminator.
      bv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
      do_store(2'd3, bv, 8, 1'b1, "store_full");
      check_eq("store_full_addr31", mem[31], 8'h38);

      do_load(2'd1, 1'b1, "load_ab");
      do_load(2'd3, 1'b0, "load_full");
      do_clear("clear");
      do_load(2'd3, 1'b1, "load_cleared");

      // Reset partway through a STORE: the two written bytes stay, nothing more is written.
      issue_cmd(OpStore, 2'd2, acc, "rst_store");
      send_byte(8'h55, "rst_store");
      send_byte(8'h66, "rst_store");
      step();
      #3;
      Rst = 1'b1;
      #1;
      check_eq("rst_mid_outputs", outs(), 0);
      w0 = wnm_cnt;
      step();
      step();
      @(negedge Clk);
      Rst = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h77;
      repeat (3) step();
      in_valid = 1'b0;
      check_eq("rst_no_more_writes", wnm_cnt - w0, 0);
      check_eq("rst_cmd_ready", cmd_ready, 1);
      ref_mem[16] = 8'h55;
      ref_mem[17] = 8'h66;
      mem_check("rst_partial");

      bv = '{8'h4e, 8'h61, 8'h6d, 8'h65, 8'h00, 8'h00, 8'h00, 8'h00};
      do_store(2'd0, bv, 5, 1'b1, "store_after_rst");
      do_nop("nop");

      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 9);
         s   = 2'($urandom);
         if (sel == 0) begin
            do_nop("rnd_nop");
         end else if (sel <= 4) begin
            len = $urandom_range(1, SlotLen);
            for (int k = 0; k < SlotLen; k++) bv[k] = 8'($urandom_range(1, 255));
            if (len < SlotLen) bv[len-1] = 8'h00;
            else if ($urandom_range(0, 3) == 0) bv[SlotLen-1] = 8'h00;
            do_store(s, bv, len, 1'b1, "rnd_store");
         end else if (sel <= 8) begin
            do_load(s, 1'($urandom), "rnd_load");
         end else begin
            do_clear("rnd_clear");
         end
      end

      check_eq("strobe_overlap", dual_cnt, 0);
      mem_check("final");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
